// File: rtl/inst_fetch_if.sv
// Memory-side request/grant/read-data port of the instruction-fetch stage.
// master = fetch stage, slave = instruction memory.
interface inst_fetch_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one outstanding req/gnt/rvalid fetch, valid/ready output register, flush.
// Optional one-entry last-fetch buffer enabled by defining IF_LAST_HIT_EN.
module inst_fetch #(
   parameter int unsigned ADDR_W   = 32,
   parameter logic [31:0] NOP_INST = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic        pc_valid,
   output logic        pc_ack,
   input  logic        flush,
   inst_fetch_if.master mem,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        fetch_busy
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] inst_q;
   logic        load_pc, capture, take_hit, drop_valid, hit_now;

`ifdef IF_LAST_HIT_EN
   logic        hit_v;
   logic [31:0] hit_pc;
   logic [31:0] hit_inst;

   assign hit_now = hit_v && (pc == hit_pc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_v    <= 1'b0;
         hit_pc   <= '0;
         hit_inst <= '0;
      end else if (flush) begin
         hit_v <= 1'b0;
      end else if (capture) begin
         hit_v    <= 1'b1;
         hit_pc   <= addr_q;
         hit_inst <= mem.mem_rdata;
      end
   end
`else
   assign hit_now = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      pc_ack     = 1'b0;
      mem.mem_req = 1'b0;
      load_pc    = 1'b0;
      capture    = 1'b0;
      take_hit   = 1'b0;
      drop_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (!flush && pc_valid) begin
               pc_ack  = 1'b1;
               load_pc = 1'b1;
               if (hit_now) begin
                  take_hit = 1'b1;
                  state_d  = HOLD;
               end else begin
                  state_d  = REQ;
               end
            end
         end
         REQ: begin
            // req stays up even under flush so a same-cycle grant is still tracked
            mem.mem_req = 1'b1;
            if (flush)            state_d = mem.mem_gnt ? DRAIN : IDLE;
            else if (mem.mem_gnt) state_d = WAIT;
         end
         WAIT: begin
            if (flush) begin
               state_d = mem.mem_rvalid ? IDLE : DRAIN;
            end else if (mem.mem_rvalid) begin
               capture = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (flush) begin
               drop_valid = 1'b1;
               state_d    = IDLE;
            end else if (inst_ready) begin
               drop_valid = 1'b1;
               state_d    = IDLE;
               if (pc_valid) begin
                  pc_ack  = 1'b1;
                  load_pc = 1'b1;
                  if (hit_now) begin
                     take_hit = 1'b1;
                     state_d  = HOLD;
                  end else begin
                     state_d  = REQ;
                  end
               end
            end
         end
         DRAIN: begin
            // the orphaned response ends the drain even if another flush arrives with it
            if (mem.mem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         inst_q     <= NOP_INST;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
      end else begin
         if (load_pc) addr_q <= pc;
         if (capture) begin
            inst_q     <= mem.mem_rdata;
            inst_pc    <= addr_q;
            inst_valid <= 1'b1;
         end else if (take_hit) begin
`ifdef IF_LAST_HIT_EN
            inst_q     <= hit_inst;
`endif
            inst_pc    <= pc;
            inst_valid <= 1'b1;
         end else if (drop_valid) begin
            inst_q     <= NOP_INST;
            inst_valid <= 1'b0;
         end
      end
   end

   assign mem.mem_addr = ADDR_W'({addr_q, 2'b00});
   assign inst         = inst_q;
   assign fetch_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, basic fetch, backpressure, grant stall, flushes,
// address truncation and the repeat-fetch behaviour (buffer hit when IF_LAST_HIT_EN is defined).
module tb_inst_fetch;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        pc_valid;
   logic        pc_ack;
   logic        flush;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        fetch_busy;
   int          total = 0;
   int          bad = 0;

   inst_fetch_if #(.ADDR_W(32)) mem_bus ();

   inst_fetch #(.ADDR_W(32), .NOP_INST(NOP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc         (pc),
      .pc_valid   (pc_valid),
      .pc_ack     (pc_ack),
      .flush      (flush),
      .mem        (mem_bus),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .fetch_busy (fetch_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0; inst_ready = 1'b0;
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
      tick(); tick();
      #1;
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst, NOP);
      chk("rst_req", mem_bus.mem_req, 0);
      rst_n = 1'b1;
      tick();

      // 1: reset mid-WAIT, late rvalid ignored
      pc = 32'd3; pc_valid = 1'b1; #1;
      chk("t1_ack", pc_ack, 1);
      tick();
      pc_valid = 1'b0; mem_bus.mem_gnt = 1'b1; #1;
      chk("t1_req", mem_bus.mem_req, 1);
      chk("t1_addr", mem_bus.mem_addr, 32'hC);
      tick();
      mem_bus.mem_gnt = 1'b0; #1;
      chk("t1_wait_busy", fetch_busy, 1);
      rst_n = 1'b0; #1;
      chk("t1_rst_req", mem_bus.mem_req, 0);
      chk("t1_rst_addr", mem_bus.mem_addr, 0);
      chk("t1_rst_busy", fetch_busy, 0);
      chk("t1_rst_inst", inst, NOP);
      chk("t1_rst_ipc", inst_pc, 0);
      chk("t1_rst_valid", inst_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1111_1111;
      tick();
      mem_bus.mem_rvalid = 1'b0; #1;
      chk("t1_late_valid", inst_valid, 0);
      chk("t1_late_inst", inst, NOP);
      chk("t1_late_busy", fetch_busy, 0);

      // 2: basic fetch, pc=5
      pc = 32'd5; pc_valid = 1'b1; #1;
      chk("t2_ack", pc_ack, 1);
      chk("t2_req_t0", mem_bus.mem_req, 0);
      tick();
      pc_valid = 1'b0; mem_bus.mem_gnt = 1'b1; #1;
      chk("t2_req_t1", mem_bus.mem_req, 1);
      chk("t2_addr", mem_bus.mem_addr, 32'h14);
      chk("t2_ack_t1", pc_ack, 0);
      tick();
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h2408_000A; #1;
      chk("t2_req_t2", mem_bus.mem_req, 0);
      chk("t2_valid_t2", inst_valid, 0);
      tick();
      mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'hFFFF_FFFF; #1;
      chk("t2_inst", inst, 32'h2408_000A);
      chk("t2_ipc", inst_pc, 5);
      chk("t2_valid", inst_valid, 1);

      // 3: backpressure in HOLD, then back-to-back accept of pc=6
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_hold_inst", inst, 32'h2408_000A);
         chk("t3_hold_valid", inst_valid, 1);
         chk("t3_hold_req", mem_bus.mem_req, 0);
      end
      inst_ready = 1'b1; pc_valid = 1'b1; pc = 32'd6; #1;
      chk("t3_ack", pc_ack, 1);
      tick();
      inst_ready = 1'b0; pc_valid = 1'b0; #1;
      chk("t3_req", mem_bus.mem_req, 1);
      chk("t3_addr", mem_bus.mem_addr, 32'h18);
      chk("t3_valid_off", inst_valid, 0);
      chk("t3_inst_nop", inst, NOP);

      // 4: grant stall holds request, no pc_ack
      pc_valid = 1'b1; pc = 32'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_req", mem_bus.mem_req, 1);
         chk("t4_addr", mem_bus.mem_addr, 32'h18);
         chk("t4_ack", pc_ack, 0);
         tick();
      end
      pc_valid = 1'b0; mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hAAAA_0006;
      tick();
      mem_bus.mem_rvalid = 1'b0; #1;
      chk("t4_inst", inst, 32'hAAAA_0006);
      chk("t4_ipc", inst_pc, 6);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0; #1;
      chk("t4_idle", fetch_busy, 0);
      chk("t4_valid_off", inst_valid, 0);

      // 5: flush in WAIT -> DRAIN, orphan data dropped
      pc = 32'd9; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0; mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0; flush = 1'b1; #1;
      chk("t5_req_wait", mem_bus.mem_req, 0);
      tick();
      flush = 1'b0; #1;
      chk("t5_drain_busy", fetch_busy, 1);
      chk("t5_drain_req", mem_bus.mem_req, 0);
      tick();
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h0000_0BAD; #1;
      chk("t5_t4_valid", inst_valid, 0);
      tick();
      mem_bus.mem_rvalid = 1'b0; #1;
      chk("t5_idle", fetch_busy, 0);
      chk("t5_valid", inst_valid, 0);
      chk("t5_inst", inst, NOP);
      pc = 32'd10; pc_valid = 1'b1; #1;
      chk("t5_ack", pc_ack, 1);
      tick();
      pc_valid = 1'b0; mem_bus.mem_gnt = 1'b1; #1;
      chk("t5_addr", mem_bus.mem_addr, 32'h28);
      tick();
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1234_5678;
      tick();
      mem_bus.mem_rvalid = 1'b0; #1;
      chk("t5_inst2", inst, 32'h1234_5678);
      chk("t5_ipc2", inst_pc, 10);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;

      // flush beats pc_valid in IDLE; pc wrap truncation; flush in HOLD
      flush = 1'b1; pc = 32'hFFFF_FFFF; pc_valid = 1'b1; #1;
      chk("fl_idle_ack", pc_ack, 0);
      tick();
      chk("fl_idle_busy", fetch_busy, 0);
      flush = 1'b0; #1;
      chk("wrap_ack", pc_ack, 1);
      tick();
      pc_valid = 1'b0; mem_bus.mem_gnt = 1'b1; #1;
      chk("wrap_addr", mem_bus.mem_addr, 32'hFFFF_FFFC);
      tick();
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h0000_0055;
      tick();
      mem_bus.mem_rvalid = 1'b0; flush = 1'b1; inst_ready = 1'b0; #1;
      chk("wrap_ipc", inst_pc, 32'hFFFF_FFFF);
      tick();
      flush = 1'b0; #1;
      chk("fl_hold_valid", inst_valid, 0);
      chk("fl_hold_inst", inst, NOP);
      chk("fl_hold_busy", fetch_busy, 0);

      // flush in REQ without grant -> IDLE
      pc = 32'd2; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; #1;
      chk("fl_req_busy", fetch_busy, 0);
      chk("fl_req_req", mem_bus.mem_req, 0);

      // 6: fetch pc=8 twice, then again after a flush
      pc = 32'd8; pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0; mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1000_FFFF;
      tick();
      mem_bus.mem_rvalid = 1'b0; #1;
      chk("t6_inst1", inst, 32'h1000_FFFF);
      inst_ready = 1'b1; pc_valid = 1'b1; pc = 32'd8; #1;
      chk("t6_ack2", pc_ack, 1);
      tick();
      inst_ready = 1'b0; pc_valid = 1'b0; #1;
`ifdef IF_LAST_HIT_EN
      chk("t6_hit_req", mem_bus.mem_req, 0);
      chk("t6_hit_valid", inst_valid, 1);
      chk("t6_hit_inst", inst, 32'h1000_FFFF);
      chk("t6_hit_ipc", inst_pc, 8);
`else
      chk("t6_miss_req", mem_bus.mem_req, 1);
      chk("t6_miss_addr", mem_bus.mem_addr, 32'h20);
      chk("t6_miss_valid", inst_valid, 0);
      mem_bus.mem_gnt = 1'b1;
      tick();
      mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h1000_FFFF;
      tick();
      mem_bus.mem_rvalid = 1'b0; #1;
      chk("t6_miss_inst", inst, 32'h1000_FFFF);
`endif
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; pc = 32'd8; pc_valid = 1'b1; #1;
      chk("t6_ack3", pc_ack, 1);
      tick();
      pc_valid = 1'b0; #1;
      chk("t6_flush_req", mem_bus.mem_req, 1);
      chk("t6_flush_addr", mem_bus.mem_addr, 32'h20);
      chk("t6_flush_valid", inst_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
